// File: rtl/eth4to1_pll_rst_ctrl.sv
// rtl/eth4to1_pll_rst_ctrl.sv - PLL reset/lock sequencer for the eth4to1 PLL
//
// Purpose: pulses the PLL reset, waits for a synchronised lock, requires the
// lock to hold for LOCK_STABLE_CYCLES, then releases the downstream reset.
// Re-resets the PLL on loss of lock or on request, counts relocks and flags
// lock timeouts.
//
// Optional feature macro: ETH4TO1_PLL_RST_DEGLITCH_EN
//   defined   - loss of lock in RUN needs 4 consecutive low lock_s cycles
//   undefined - a single low lock_s cycle in RUN is loss of lock
//
// Ports:
//   refclk        in   reference clock
//   rst_n         in   asynchronous active-low reset
//   pll_locked    in   PLL lock, asynchronous to refclk
//   force_relock  in   single-cycle request to re-reset the PLL
//   err_clr       in   clears timeout_err
//   pll_rst       out  active-high PLL reset
//   sys_rst_n     out  active-low reset for PLL-clocked logic
//   ready         out  high only in RUN
//   relock_count  out  saturating count of RUN exits
//   timeout_err   out  sticky lock-timeout flag
//   state_dbg     out  0 RESET_PLL, 1 WAIT_LOCK, 2 STABLE, 3 RUN
module eth4to1_pll_rst_ctrl #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int CNT_W               = 17,
  parameter int SYNC_STAGES         = 2
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       force_relock,
  input  logic       err_clr,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic [7:0] relock_count,
  output logic       timeout_err,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_RESET_PLL = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_RST_LAST  = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_STB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TMO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_pll_rst;
  logic                   r_run;
  logic [7:0]             r_relock;
  logic                   r_err;

  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_lock_s;
  logic                   w_lol;
  logic                   w_relock_inc;
  logic                   w_timeout;

  assign w_lock_s = r_sync[SYNC_STAGES-1];

`ifdef ETH4TO1_PLL_RST_DEGLITCH_EN
  // Counts consecutive low lock_s cycles in RUN; the 4th low cycle is loss.
  logic [2:0] r_glitch;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_glitch <= 3'd0;
    end else if (r_state != S_RUN || w_lock_s) begin
      r_glitch <= 3'd0;
    end else if (r_glitch != 3'd7) begin
      r_glitch <= r_glitch + 3'd1;
    end
  end

  assign w_lol = !w_lock_s && (r_glitch == 3'd3);
`else
  assign w_lol = !w_lock_s;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_relock_inc = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_RESET_PLL: begin
        if (r_cnt == C_RST_LAST) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        // A relock request overrides both lock arrival and timeout.
        if (force_relock) begin
          w_state_nxt = S_RESET_PLL;
          w_cnt_nxt   = '0;
        end else if (w_lock_s) begin
          w_state_nxt = S_STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_TMO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_RESET_PLL;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_STABLE: begin
        if (force_relock) begin
          w_state_nxt = S_RESET_PLL;
          w_cnt_nxt   = '0;
        end else if (!w_lock_s) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_STB_LAST) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (force_relock || w_lol) begin
          w_state_nxt  = S_RESET_PLL;
          w_cnt_nxt    = '0;
          w_relock_inc = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_RESET_PLL;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register itself.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_RESET_PLL;
      r_cnt     <= '0;
      r_sync    <= '0;
      r_pll_rst <= 1'b1;
      r_run     <= 1'b0;
      r_relock  <= 8'd0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sync    <= {r_sync[SYNC_STAGES-2:0], pll_locked};
      r_pll_rst <= (w_state_nxt == S_RESET_PLL);
      r_run     <= (w_state_nxt == S_RUN);
      if (w_relock_inc && r_relock != 8'hFF) begin
        r_relock <= r_relock + 8'd1;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign pll_rst      = r_pll_rst;
  assign sys_rst_n    = r_run;
  assign ready        = r_run;
  assign relock_count = r_relock;
  assign timeout_err  = r_err;
  assign state_dbg    = r_state;

endmodule
